div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving operand and result width in bits.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port div_in.rdata1, input, XLEN bits: dividend.
REQ-005 SHALL have port div_in.rdata2, input, XLEN bits: divisor.
REQ-006 SHALL have port div_in.enable, input, 1 bit: request from the execute stage (division op AND stage enable).
REQ-007 SHALL have port div_in.div_op, input, 4 bits, one-hot {remu,rem,divu,div} at bits [3:0]: operation select.
REQ-008 SHALL have port div_out.result, output, XLEN bits: quotient or remainder.
REQ-009 SHALL have port div_out.ready, output, 1 bit: result valid in this cycle.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 In IDLE with enable=1 at edge T, SHALL latch the operands and div_op, and load the iteration counter with XLEN-1.
REQ-012 From IDLE, SHALL enter BUSY at T+1, or DONE at T+1 on a fast-path case (REQ-018..020).
REQ-013 BUSY SHALL perform one restoring radix-2 step per cycle on operand magnitudes: shift partial remainder left, bring in the next dividend bit, subtract the divisor when no borrow results, and set the quotient bit.
REQ-014 BUSY SHALL decrement the counter each cycle and go to DONE after the step taken at count 0.
REQ-015 The normal path SHALL take exactly XLEN BUSY cycles (T+1..T+XLEN), with DONE at T+XLEN+1.
REQ-016 DONE SHALL drive ready=1 for exactly one cycle and present the final result registered.
REQ-017 DONE SHALL go to IDLE unconditionally; enable still high during DONE SHALL NOT start a new operation.
REQ-018 div/rem SHALL treat operands as two's complement.
  - Quotient negated when operand signs differ.
  - Remainder takes the dividend's sign.
  - divu/remu SHALL be unsigned.
REQ-019 Divisor = 0 (fast path): quotient = all ones; remainder = dividend unchanged.
REQ-020 Signed overflow (dividend = -2^(XLEN-1), divisor = -1, fast path): quotient = -2^(XLEN-1); remainder = 0.
REQ-021 enable=1 with div_op all-zero (fast path): result = 0.
REQ-022 div/divu SHALL output the quotient; rem/remu SHALL output the remainder.
REQ-023 In BUSY, operand/div_op changes SHALL be ignored.
REQ-024 In BUSY, enable=0 (pipeline clear/trap) SHALL abort: return to IDLE next cycle, no ready pulse.
REQ-025 ready SHALL be 0 in IDLE and BUSY.
REQ-026 result SHALL hold its last DONE value outside DONE.
REQ-027 Back-to-back operations: a request in the IDLE cycle directly after DONE SHALL be accepted with the normal latency.
REQ-028 Negation SHALL be XLEN-bit wrap-around; the partial remainder SHALL be XLEN+1 bits internally.

Reset
REQ-029 reset=0 SHALL immediately force, regardless of clock:
  - state = IDLE;
  - counter = 0;
  - operand, quotient and remainder registers = 0;
  - ready = 0;
  - result = 0.
REQ-030 reset asserted mid-operation SHALL discard it; after release, the unit SHALL accept a new request in IDLE.

Verification
REQ-031 divu 100 / 7, enable held: ready=1 exactly at T+33; result = 14; ready=0 at T+34.
REQ-032 rem -7 / 2: result = -1 (0xFFFFFFFF); div -7 / 2: result = -3 (0xFFFFFFFD); each at T+33.
REQ-033 div 5 / 0: ready at T+1, result = 0xFFFFFFFF; remu 5 / 0: result = 5.
REQ-034 div 0x80000000 / 0xFFFFFFFF: ready at T+1, result = 0x80000000; rem with the same operands: result = 0.
REQ-035 divu 100 / 7 with enable dropped at T+10: no ready pulse; IDLE at T+11; new divu 9 / 3 at T+11 gives result 3 at T+44.
REQ-036 reset pulsed low at T+5 of an operation: ready and result = 0 immediately; no ready pulse afterwards without a new request.

Source files
------------

// File: rtl/div_unit_if.sv
// Request and response bundles between the execute stage and the iterative divider.
interface div_in_if #(parameter int unsigned XLEN = 32);
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            enable;
  logic [3:0]      div_op;

  modport master (output rdata1, output rdata2, output enable, output div_op);
  modport slave  (input  rdata1, input  rdata2, input  enable, input  div_op);
endinterface

interface div_out_if #(parameter int unsigned XLEN = 32);
  logic [XLEN-1:0] result;
  logic            ready;

  modport master (output result, output ready);
  modport slave  (input  result, input  ready);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for div/divu/rem/remu.
// Handles divide-by-zero, signed overflow and null-op requests in a single cycle.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_in_if.slave    div_in,
  div_out_if.master  div_out
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int unsigned RW    = XLEN + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             ready_q, ready_d;

  // One restoring step: shift in the next dividend bit, subtract if no borrow.
  logic [RW-1:0]   shifted, diff, step_rem;
  logic            step_bit;
  logic [XLEN-1:0] step_quo, fin_quo, fin_rem;

  assign shifted  = RW'({rem_q, quo_q[XLEN-1]});
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_bit = ~diff[RW-1];
  assign step_rem = step_bit ? diff : shifted;
  assign step_quo = {quo_q[XLEN-2:0], step_bit};
  assign fin_quo  = neg_quo_q ? (~step_quo + XLEN'(1)) : step_quo;
  assign fin_rem  = neg_rem_q ? (~step_rem[XLEN-1:0] + XLEN'(1)) : step_rem[XLEN-1:0];

  // Request decode, operand magnitudes and single-cycle special cases.
  logic            signed_op, rem_op, neg_a, neg_b, ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign signed_op = div_in.div_op[0] | div_in.div_op[2];
  assign rem_op    = div_in.div_op[3] | div_in.div_op[2];
  assign neg_a     = signed_op & div_in.rdata1[XLEN-1];
  assign neg_b     = signed_op & div_in.rdata2[XLEN-1];
  assign mag_a     = neg_a ? (~div_in.rdata1 + XLEN'(1)) : div_in.rdata1;
  assign mag_b     = neg_b ? (~div_in.rdata2 + XLEN'(1)) : div_in.rdata2;
  assign ovf       = signed_op && (div_in.rdata1 == MIN_NEG) && (div_in.rdata2 == '1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (div_in.enable) begin
          cnt_d     = CNT_W'(XLEN - 1);
          dvs_d     = mag_b;
          quo_d     = mag_a;
          rem_d     = '0;
          neg_quo_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          is_rem_d  = rem_op;
          if (div_in.div_op == 4'b0000) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = '0;
          end else if (div_in.rdata2 == '0) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = rem_op ? div_in.rdata1 : '1;
          end else if (ovf) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = rem_op ? '0 : div_in.rdata1;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        // Dropping enable mid-operation is a pipeline flush: abandon silently.
        if (!div_in.enable) begin
          state_d = IDLE;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            cnt_d    = '0;
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = is_rem_q ? fin_rem : fin_quo;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign div_out.result = result_q;
  assign div_out.ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed test of div_unit: vector table for results/latency plus abort, reset and back-to-back sequences.
module tb_div_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_DIVU = 4'b0010;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b1000;
  localparam int NORM = 33;
  localparam int FAST = 1;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] last_exp;

  div_in_if  #(.XLEN(XLEN)) din ();
  div_out_if #(.XLEN(XLEN)) dout ();

  div_unit #(.XLEN(XLEN)) dut (
    .clock   (clock),
    .reset   (reset),
    .div_in  (din),
    .div_out (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered #1 after a rising edge with the DUT idle; leaves it idle with enable low.
  task automatic run_op(input vec_t v);
    int          lat;
    logic [31:0] res;
    lat = 0;
    res = '0;
    din.enable = 1'b1;
    din.div_op = v.op;
    din.rdata1 = v.a;
    din.rdata2 = v.b;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clock); #1;
      if (dout.ready) begin
        lat = k;
        res = dout.result;
      end
      if (k == 1) begin
        din.rdata1 = ~v.a;
        din.rdata2 = v.b ^ 32'h0000_0005;
        din.div_op = ~v.op;
      end
    end
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " result"}, res, v.exp);
    @(posedge clock); #1;
    check({v.name, " ready low after"}, 32'(dout.ready), 32'(0));
    check({v.name, " result hold"}, dout.result, v.exp);
    din.enable = 1'b0;
    last_exp = v.exp;
  endtask

  vec_t vecs[20];

  initial begin
    int          rdy_seen;
    int          lat;
    int          first_rdy;
    int          second_rdy;
    logic [31:0] res1;
    logic [31:0] res2;

    vecs[0]  = '{"divu 100/7",       OP_DIVU, 32'd100,       32'd7,         32'd14,        NORM};
    vecs[1]  = '{"remu 100/7",       OP_REMU, 32'd100,       32'd7,         32'd2,         NORM};
    vecs[2]  = '{"rem -7/2",         OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORM};
    vecs[3]  = '{"div -7/2",         OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORM};
    vecs[4]  = '{"div 5/0",          OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, FAST};
    vecs[5]  = '{"remu 5/0",         OP_REMU, 32'd5,         32'd0,         32'd5,         FAST};
    vecs[6]  = '{"div ovf",          OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST};
    vecs[7]  = '{"rem ovf",          OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         FAST};
    vecs[8]  = '{"div 7/-2",         OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM};
    vecs[9]  = '{"rem 7/-2",         OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         NORM};
    vecs[10] = '{"div -8/-3",        OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         NORM};
    vecs[11] = '{"rem -8/-3",        OP_REM,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, NORM};
    vecs[12] = '{"divu max/1",       OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, NORM};
    vecs[13] = '{"divu 2^31/max",    OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         NORM};
    vecs[14] = '{"remu 2^31/max",    OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORM};
    vecs[15] = '{"null op",          4'b0000, 32'd123,       32'd4,         32'd0,         FAST};
    vecs[16] = '{"div min/3",        OP_DIV,  32'h8000_0000, 32'd3,         32'hD555_5556, NORM};
    vecs[17] = '{"rem min/3",        OP_REM,  32'h8000_0000, 32'd3,         32'hFFFF_FFFE, NORM};
    vecs[18] = '{"divu deadbeef/16", OP_DIVU, 32'hDEAD_BEEF, 32'd16,        32'h0DEA_DBEE, NORM};
    vecs[19] = '{"remu deadbeef/16", OP_REMU, 32'hDEAD_BEEF, 32'd16,        32'h0000_000F, NORM};

    total      = 0;
    bad        = 0;
    last_exp   = '0;
    reset      = 1'b0;
    din.enable = 1'b0;
    din.div_op = 4'b0000;
    din.rdata1 = '0;
    din.rdata2 = '0;

    #2;
    check("reset ready", 32'(dout.ready), 32'(0));
    check("reset result", dout.result, 32'd0);
    @(posedge clock); @(posedge clock); #7;
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i]);
      @(posedge clock); #1;
    end

    // Abort: enable dropped during BUSY at T+10, new request at T+11.
    din.enable = 1'b1; din.div_op = OP_DIVU; din.rdata1 = 32'd100; din.rdata2 = 32'd7;
    rdy_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      if (dout.ready) rdy_seen++;
      if (k == 10) din.enable = 1'b0;
    end
    @(posedge clock); #1;
    if (dout.ready) rdy_seen++;
    check("abort no ready", rdy_seen, 0);
    check("abort result hold", dout.result, last_exp);
    din.enable = 1'b1; din.div_op = OP_DIVU; din.rdata1 = 32'd9; din.rdata2 = 32'd3;
    lat = 0; res1 = '0;
    for (int k = 12; k <= 60 && lat == 0; k++) begin
      @(posedge clock); #1;
      if (dout.ready) begin lat = k; res1 = dout.result; end
    end
    check("after abort latency", lat, 44);
    check("after abort result", res1, 32'd3);
    din.enable = 1'b0;
    @(posedge clock); #1;

    // Reset pulsed at T+5 of a running operation.
    din.enable = 1'b1; din.div_op = OP_DIV; din.rdata1 = 32'd100; din.rdata2 = 32'd7;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1;
    check("mid reset ready", 32'(dout.ready), 32'(0));
    check("mid reset result", dout.result, 32'd0);
    din.enable = 1'b0;
    #3 reset = 1'b1;
    rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (dout.ready) rdy_seen++;
    end
    check("post reset no ready", rdy_seen, 0);
    check("post reset result", dout.result, 32'd0);
    run_op('{"post reset divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, NORM});
    @(posedge clock); #1;

    // Back-to-back with enable held: DONE ignores it, next IDLE accepts.
    din.enable = 1'b1; din.div_op = OP_DIVU; din.rdata1 = 32'd100; din.rdata2 = 32'd7;
    first_rdy = 0; second_rdy = 0; res1 = '0; res2 = '0;
    for (int k = 1; k <= 80 && second_rdy == 0; k++) begin
      @(posedge clock); #1;
      if (dout.ready) begin
        if (first_rdy == 0) begin first_rdy = k; res1 = dout.result; end
        else begin second_rdy = k; res2 = dout.result; end
      end
      if (k == 33) begin din.rdata1 = 32'd9; din.rdata2 = 32'd3; end
    end
    check("b2b first latency", first_rdy, 33);
    check("b2b first result", res1, 32'd14);
    check("b2b second latency", second_rdy, 67);
    check("b2b second result", res2, 32'd3);
    din.enable = 1'b0;
    @(posedge clock); #1;
    check("b2b ready low", 32'(dout.ready), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
